mem_arbiter: RTL

- Shares one single-port unified memory between instruction fetch (IF) and the load/store stage (MEM) of the RISC-V core.
- Grants one requester at a time and drives a registered req/ack transaction to the RAM.
- Returns read data with a one-cycle valid pulse and produces stall signals for the pipeline.
- Data accesses have priority over fetch; a starvation guard and a timeout bound the wait for each side.

---
 rtl/mem_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/MEM arbiter for a shared single-port memory
// Data wins over fetch except when the starve counter is saturated.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  if_valid_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic                  mem_addrmode_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic                  mem_valid_o,
  output logic                  stall_f_o,
  output logic                  stall_m_o,
  output logic                  bus_err_o,
  output logic                  ram_req_o,
  output logic                  ram_we_o,
  output logic                  ram_addrmode_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  input  logic                  ram_ack_i
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SERVE_IF  = 2'd1;
  localparam logic [1:0] SERVE_MEM = 2'd2;

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  logic [1:0]            state_q, state_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  ram_req_q, ram_req_d;
  logic                  ram_we_q, ram_we_d;
  logic                  ram_mode_q, ram_mode_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
  logic                  if_valid_q, if_valid_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  bus_err_q, bus_err_d;
  logic                  grant_mem;
  logic                  timed_out;

  assign timed_out = (tmo_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_mode_d  = ram_mode_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_valid_d  = 1'b0;
    mem_valid_d = 1'b0;
    bus_err_d   = 1'b0;
    grant_mem   = mem_req_i && !(if_req_i && (starve_q == STARVE_MAX));

    case (state_q)
      IDLE: begin
        // Hold off one cycle after a completion so a requester still holding
        // req during its valid cycle is not served twice.
        if (!(if_valid_q || mem_valid_q)) begin
          if (grant_mem) begin
            state_d     = SERVE_MEM;
            ram_req_d   = 1'b1;
            ram_we_d    = mem_we_i;
            ram_mode_d  = mem_addrmode_i;
            ram_addr_d  = mem_addr_i;
            ram_wdata_d = mem_wdata_i;
            tmo_d       = '0;
            if (if_req_i && (starve_q != STARVE_MAX)) begin
              starve_d = starve_q + SW'(1);
            end
          end else if (if_req_i) begin
            state_d     = SERVE_IF;
            ram_req_d   = 1'b1;
            ram_we_d    = 1'b0;
            ram_mode_d  = 1'b0;
            ram_addr_d  = if_addr_i;
            ram_wdata_d = '0;
            tmo_d       = '0;
            starve_d    = '0;
          end
        end
      end
      SERVE_IF: begin
        if (ram_ack_i) begin
          if_rdata_d = ram_rdata_i;
          if_valid_d = 1'b1;
          ram_req_d  = 1'b0;
          state_d    = IDLE;
        end else if (timed_out) begin
          if_rdata_d = '0;
          if_valid_d = 1'b1;
          bus_err_d  = 1'b1;
          ram_req_d  = 1'b0;
          state_d    = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      SERVE_MEM: begin
        if (ram_ack_i) begin
          mem_rdata_d = ram_rdata_i;
          mem_valid_d = 1'b1;
          ram_req_d   = 1'b0;
          state_d     = IDLE;
        end else if (timed_out) begin
          mem_rdata_d = '0;
          mem_valid_d = 1'b1;
          bus_err_d   = 1'b1;
          ram_req_d   = 1'b0;
          state_d     = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        ram_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      tmo_q       <= '0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_mode_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_mode_q  <= ram_mode_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_valid_q  <= if_valid_d;
      mem_valid_q <= mem_valid_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign ram_req_o      = ram_req_q;
  assign ram_we_o       = ram_we_q;
  assign ram_addrmode_o = ram_mode_q;
  assign ram_addr_o     = ram_addr_q;
  assign ram_wdata_o    = ram_wdata_q;
  assign if_rdata_o     = if_rdata_q;
  assign mem_rdata_o    = mem_rdata_q;
  assign if_valid_o     = if_valid_q;
  assign mem_valid_o    = mem_valid_q;
  assign bus_err_o      = bus_err_q;
  assign stall_f_o      = if_req_i & ~if_valid_q;
  assign stall_m_o      = mem_req_i & ~mem_valid_q;

endmodule
